// File: rtl/multiport_qdr_rr.sv
// N-port command arbiter in front of a single QDR SRAM controller port.
// Reads are tagged with their port so returning data is steered back by a latency-matched pipe.
module multiport_qdr_rr #(
    parameter int C_NUM_PORTS     = 2,
    parameter int C_WIDE_DATA     = 0,
    parameter int QDR_LATENCY     = 10,
    parameter int C_PRIORITY_MODE = 0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [C_NUM_PORTS*32-1:0]                  in_cmd_addr,
    input  logic [C_NUM_PORTS-1:0]                     in_wr_strb,
    input  logic [C_NUM_PORTS*36*(1+C_WIDE_DATA)-1:0]  in_wr_data,
    input  logic [C_NUM_PORTS*4*(1+C_WIDE_DATA)-1:0]   in_wr_be,
    input  logic [C_NUM_PORTS-1:0]                     in_rd_strb,
    output logic [C_NUM_PORTS-1:0]                     in_cmd_ack,
    output logic [C_NUM_PORTS-1:0]                     in_rd_dvld,
    output logic [36*(1+C_WIDE_DATA)-1:0]              in_rd_data,
    output logic [31:0]                                out_cmd_addr,
    output logic                                       out_wr_strb,
    output logic [36*(1+C_WIDE_DATA)-1:0]              out_wr_data,
    output logic [4*(1+C_WIDE_DATA)-1:0]               out_wr_be,
    output logic                                       out_rd_strb,
    input  logic                                       out_rd_dvld,
    input  logic [36*(1+C_WIDE_DATA)-1:0]              out_rd_data,
    output logic                                       rd_err
);

    localparam int N  = C_NUM_PORTS;
    localparam int D  = 36 * (1 + C_WIDE_DATA);
    localparam int B  = 4 * (1 + C_WIDE_DATA);
    localparam int PW = $clog2(C_NUM_PORTS);
    localparam int L  = QDR_LATENCY;

    logic [N-1:0]  req;
    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] last_grant;
    logic [PW-1:0] wsel;
    logic          wsel_vld;
    logic [31:0]   gnt_addr;
    logic [D-1:0]  gnt_data;
    logic [B-1:0]  gnt_be;
    logic          gnt_wr;
    logic          gnt_rd;
    logic [D-1:0]  wsel_data;
    logic [B-1:0]  wsel_be;
    logic [L-1:0]  tag_vld;
    logic [PW-1:0] tag_port [L];

    assign req        = in_wr_strb | in_rd_strb;
    assign in_rd_data = out_rd_data;

    // Grant: scan from the port after the last winner, or from port 0 in fixed-priority mode.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (C_PRIORITY_MODE != 0) begin
                scan_idx = PW'(k);
            end else begin
                scan_idx = PW'((int'(last_grant) + 1 + k) % N);
            end
            if (!gnt_any && req[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    always_comb begin
        in_cmd_ack = '0;
        in_rd_dvld = '0;
        gnt_addr   = '0;
        gnt_data   = '0;
        gnt_be     = '0;
        gnt_wr     = 1'b0;
        gnt_rd     = 1'b0;
        wsel_data  = '0;
        wsel_be    = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == PW'(i)) begin
                in_cmd_ack[i] = gnt_any;
                gnt_addr      = in_cmd_addr[i*32 +: 32];
                gnt_data      = in_wr_data[i*D +: D];
                gnt_be        = in_wr_be[i*B +: B];
                gnt_wr        = in_wr_strb[i];
                gnt_rd        = in_rd_strb[i];
            end
            if (wsel == PW'(i)) begin
                wsel_data = in_wr_data[i*D +: D];
                wsel_be   = in_wr_be[i*B +: B];
            end
            if (tag_port[L-1] == PW'(i)) begin
                in_rd_dvld[i] = tag_vld[L-1];
            end
        end
    end

    // Stage p0: command towards the controller, plus the second write beat from wsel.
    // A new write's first beat takes the data register over a previous burst's second beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant   <= PW'(N - 1);
            wsel         <= '0;
            wsel_vld     <= 1'b0;
            out_wr_strb  <= 1'b0;
            out_rd_strb  <= 1'b0;
            out_cmd_addr <= '0;
            out_wr_data  <= '0;
            out_wr_be    <= '0;
        end else begin
            out_wr_strb <= gnt_any & gnt_wr;
            out_rd_strb <= gnt_any & gnt_rd;
            wsel_vld    <= gnt_any & gnt_wr;
            if (gnt_any) begin
                last_grant   <= gnt_idx;
                wsel         <= gnt_idx;
                out_cmd_addr <= gnt_addr;
            end
            if (gnt_any && gnt_wr) begin
                out_wr_data <= gnt_data;
                out_wr_be   <= gnt_be;
            end else if (wsel_vld) begin
                out_wr_data <= wsel_data;
                out_wr_be   <= wsel_be;
            end
        end
    end

    // Stage p1..pL: read tag pipe, fed from the registered read strobe and its port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            rd_err  <= 1'b0;
        end else begin
            tag_vld <= {tag_vld[L-2:0], out_rd_strb};
            if (out_rd_dvld != tag_vld[L-1]) begin
                rd_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_port[0] <= last_grant;
        for (int i = 1; i < L; i++) begin
            tag_port[i] <= tag_port[i-1];
        end
    end

endmodule

// File: tb/tb_multiport_qdr_rr.sv
// Bench for multiport_qdr_rr: randomized requesters against a cycle-level reference model.
// A round-robin instance is fully modelled; a fixed-priority instance is checked on its grants.
module tb_multiport_qdr_rr;

    localparam int N  = 4;
    localparam int WD = 0;
    localparam int L  = 10;
    localparam int D  = 36;
    localparam int B  = 4;
    localparam int PW = 2;
    localparam int VW = N + 2 + 32 + D + B + N + D + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [N*32-1:0] addr_bus;
    logic [N-1:0]    wr, rd;
    logic [N*D-1:0]  wdata_bus;
    logic [N*B-1:0]  be_bus;
    logic            ctl_dvld;
    logic [D-1:0]    ctl_rdata;

    logic [N-1:0] ack, dvld;
    logic [D-1:0] rdata, o_wdata;
    logic [31:0]  o_addr;
    logic         o_wr, o_rd, err;
    logic [B-1:0] o_be;

    logic [N-1:0] fp_ack, fp_dvld;
    logic [D-1:0] fp_rdata, fp_wdata;
    logic [31:0]  fp_addr;
    logic         fp_wr, fp_rd, fp_err;
    logic [B-1:0] fp_be;

    always #5 clk = ~clk;

    multiport_qdr_rr #(.C_NUM_PORTS(N), .C_WIDE_DATA(WD), .QDR_LATENCY(L), .C_PRIORITY_MODE(0)) dut (
        .clk(clk), .rst(rst_n), .in_cmd_addr(addr_bus), .in_wr_strb(wr), .in_wr_data(wdata_bus),
        .in_wr_be(be_bus), .in_rd_strb(rd), .in_cmd_ack(ack), .in_rd_dvld(dvld), .in_rd_data(rdata),
        .out_cmd_addr(o_addr), .out_wr_strb(o_wr), .out_wr_data(o_wdata), .out_wr_be(o_be),
        .out_rd_strb(o_rd), .out_rd_dvld(ctl_dvld), .out_rd_data(ctl_rdata), .rd_err(err));

    multiport_qdr_rr #(.C_NUM_PORTS(N), .C_WIDE_DATA(WD), .QDR_LATENCY(L), .C_PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .rst(rst_n), .in_cmd_addr(addr_bus), .in_wr_strb(wr), .in_wr_data(wdata_bus),
        .in_wr_be(be_bus), .in_rd_strb(rd), .in_cmd_ack(fp_ack), .in_rd_dvld(fp_dvld), .in_rd_data(fp_rdata),
        .out_cmd_addr(fp_addr), .out_wr_strb(fp_wr), .out_wr_data(fp_wdata), .out_wr_be(fp_be),
        .out_rd_strb(fp_rd), .out_rd_dvld(1'b0), .out_rd_data(ctl_rdata), .rd_err(fp_err));

    typedef struct {
        bit           v;
        int           port;
        bit           w;
        bit           r;
        logic [31:0]  a;
        logic [D-1:0] w0;
        logic [D-1:0] w1;
        logic [B-1:0] b0;
        logic [B-1:0] b1;
    } grant_t;

    grant_t       g_cur, g1, g2;
    int           m_last;
    logic [31:0]  m_addr;
    logic [D-1:0] m_wdata;
    logic [B-1:0] m_be;
    bit           m_err;
    int           due_cyc[$];
    int           due_port[$];
    bit           withhold;
    int           cyc;
    int           total, bad;
    logic [N-1:0]  exp_ack, exp_ack_fp, exp_dvld;
    logic [VW-1:0] exp_vec, act_vec;

    // Spec rule: first requester scanning from last+1 (or from 0 when fixed).
    function automatic logic [N-1:0] model_ack(input bit fixed, input int last);
        logic [N-1:0]  req;
        logic [PW-1:0] pi;
        req = wr | rd;
        for (int k = 0; k < N; k++) begin
            pi = fixed ? PW'(k) : PW'((last + 1 + k) % N);
            if (req[pi]) return N'(1) << pi;
        end
        return '0;
    endfunction

    task automatic model_reset();
        g_cur   = '{default: '0};
        g1      = '{default: '0};
        g2      = '{default: '0};
        m_last  = N - 1;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        m_err   = 1'b0;
        due_cyc.delete();
        due_port.delete();
        withhold = 1'b0;
        ctl_dvld = 1'b0;
    endtask

    task automatic refresh(input int p);
        addr_bus[p*32 +: 32] = $urandom;
        wdata_bus[p*D +: D]  = D'({$urandom, $urandom});
        be_bus[p*B +: B]     = B'($urandom);
    endtask

    // Mid-cycle: build expected outputs for this cycle from the grant history.
    task automatic sample();
        logic [PW-1:0] pi;
        @(negedge clk);
        exp_ack    = model_ack(1'b0, m_last);
        exp_ack_fp = model_ack(1'b1, 0);
        g_cur = '{default: '0};
        for (int p = 0; p < N; p++) begin
            pi = PW'(p);
            if (exp_ack[pi]) begin
                g_cur.v    = 1'b1;
                g_cur.port = p;
                g_cur.w    = wr[pi];
                g_cur.r    = rd[pi];
                g_cur.a    = addr_bus[p*32 +: 32];
                g_cur.w0   = wdata_bus[p*D +: D];
                g_cur.b0   = be_bus[p*B +: B];
            end
        end
        if (g1.v) begin
            g1.w1  = wdata_bus[g1.port*D +: D];
            g1.b1  = be_bus[g1.port*B +: B];
            m_addr = g1.a;
        end
        if (g1.v && g1.w) begin
            m_wdata = g1.w0;
            m_be    = g1.b0;
        end else if (g2.v && g2.w) begin
            m_wdata = g2.w1;
            m_be    = g2.b1;
        end
        exp_dvld = '0;
        if (due_cyc.size() > 0 && due_cyc[0] == cyc) exp_dvld = N'(1) << due_port[0];
        exp_vec = {exp_ack, g1.v && g1.w, g1.v && g1.r, m_addr, m_wdata, m_be, exp_dvld, ctl_rdata, m_err};
        act_vec = {ack, o_wr, o_rd, o_addr, o_wdata, o_be, dvld, rdata, err};
    endtask

    // Clock edge: retire/issue reads, update arbitration memory, drive the controller model.
    task automatic advance();
        bit due_now;
        if (!rst_n) begin
            model_reset();
        end else begin
            due_now = due_cyc.size() > 0 && due_cyc[0] == cyc;
            if (ctl_dvld != due_now) m_err = 1'b1;
            if (due_now) begin
                void'(due_cyc.pop_front());
                void'(due_port.pop_front());
            end
            if (g_cur.v && g_cur.r) begin
                due_cyc.push_back(cyc + 1 + L);
                due_port.push_back(g_cur.port);
            end
            if (g_cur.v) m_last = g_cur.port;
            g2 = g1;
            g1 = g_cur;
        end
        @(posedge clk);
        #1;
        cyc++;
        ctl_rdata = D'({$urandom, $urandom});
        ctl_dvld  = 1'b0;
        if (rst_n && due_cyc.size() > 0 && due_cyc[0] == cyc) begin
            if (withhold) withhold = 1'b0;
            else ctl_dvld = 1'b1;
        end
    endtask

    task automatic drain(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            sample();
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act_vec, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            sample();
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
            end
            if (c == 1) rst_n = 1'b1;
            advance();
        end
    endtask

    task automatic test_rr_writes();
        int cnt [N];
        for (int p = 0; p < N; p++) begin
            cnt[p] = 0;
            refresh(p);
        end
        wr = '1;
        rd = '0;
        for (int c = 0; c < 4 * N; c++) begin
            sample();
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL rr_writes cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
            end
            for (int p = 0; p < N; p++) if (ack[PW'(p)]) cnt[p]++;
            advance();
            if (g1.v) refresh(g1.port);
        end
        for (int p = 0; p < N; p++) begin
            total++;
            if (cnt[p] != 4) begin
                bad++;
                $display("FAIL rr_fairness port=%0d got=%0d want=4", p, cnt[p]);
            end
        end
        wr = '0;
        drain("rr_writes_tail", 3);
    endtask

    task automatic test_fixed_priority();
        wr = '0;
        rd = 4'b1010;
        refresh(1);
        refresh(3);
        for (int c = 0; c < 7; c++) begin
            if (c == 6) rd[1] = 1'b0;
            sample();
            total++;
            if (fp_ack !== exp_ack_fp) begin
                bad++;
                $display("FAIL fixed_prio cyc=%0d got=%b want=%b", cyc, fp_ack, exp_ack_fp);
            end
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL fp_rr_side cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
            end
            advance();
            if (g1.v) refresh(g1.port);
        end
        rd = '0;
        drain("fixed_prio_tail", L + 4);
    endtask

    task automatic test_read_latency();
        int t0;
        drain("rd_lat_idle", 2);
        rd = '0;
        rd[2] = 1'b1;
        refresh(2);
        t0 = cyc;
        drain("rd_lat_p2", 1);
        rd = '0;
        rd[0] = 1'b1;
        refresh(0);
        drain("rd_lat_p0", 1);
        rd = '0;
        for (int c = 0; c < L + 3; c++) begin
            sample();
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL rd_latency cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
            end
            if (cyc == t0 + 1 + L || cyc == t0 + 2 + L) begin
                total++;
                if (dvld !== ((cyc == t0 + 1 + L) ? 4'b0100 : 4'b0001)) begin
                    bad++;
                    $display("FAIL rd_dvld_time cyc=%0d got=%b", cyc, dvld);
                end
            end
            advance();
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL rd_err_clean got=%b want=0", err);
        end
    endtask

    task automatic test_wr_rd_same();
        refresh(1);
        addr_bus[32 +: 32] = 32'h100;
        wr = 4'b0010;
        rd = 4'b0010;
        sample();
        total++;
        if (ack !== 4'b0010 || act_vec !== exp_vec) begin
            bad++;
            $display("FAIL wr_rd_ack cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
        end
        advance();
        refresh(1);
        wr = '0;
        rd = '0;
        sample();
        total++;
        if (!(o_wr === 1'b1 && o_rd === 1'b1 && o_addr === 32'h100) || act_vec !== exp_vec) begin
            bad++;
            $display("FAIL wr_rd_issue cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
        end
        advance();
        drain("wr_rd_tail", L + 2);
    endtask

    task automatic test_random();
        int            kind;
        logic [PW-1:0] pi;
        wr = '0;
        rd = '0;
        for (int c = 0; c < 160; c++) begin
            sample();
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
            end
            advance();
            for (int p = 0; p < N; p++) begin
                pi = PW'(p);
                if (g1.v && g1.port == p) begin
                    wr[pi] = 1'b0;
                    rd[pi] = 1'b0;
                    refresh(p);
                end else if (!(wr[pi] | rd[pi]) && $urandom_range(2) == 0 && c < 150) begin
                    kind   = $urandom_range(1, 3);
                    wr[pi] = kind[0];
                    rd[pi] = kind[1];
                    refresh(p);
                end
            end
        end
        wr = '0;
        rd = '0;
        drain("random_tail", L + 3);
    endtask

    task automatic test_withhold();
        rd = 4'b1000;
        refresh(3);
        drain("withhold_issue", 1);
        rd = '0;
        withhold = 1'b1;
        drain("withhold", L + 6);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL rd_err_sticky got=%b want=1", err);
        end
    endtask

    task automatic test_reset_inflight();
        int seen;
        seen = 0;
        for (int p = 0; p < 3; p++) begin
            rd = N'(1) << p;
            refresh(p);
            drain("inflight_issue", 1);
        end
        rd = '0;
        drain("inflight_wait", 2);
        rst_n = 1'b0;
        model_reset();
        drain("inflight_reset", 2);
        rst_n = 1'b1;
        for (int c = 0; c < L + 4; c++) begin
            sample();
            total++;
            if (act_vec !== exp_vec) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec);
            end
            if (dvld !== '0) seen++;
            advance();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL discard_inflight got=%0d want=0", seen);
        end
        rd = '1;
        sample();
        total++;
        if (ack !== 4'b0001 || act_vec !== exp_vec) begin
            bad++;
            $display("FAIL first_grant_after_reset got=%b want=0001", ack);
        end
        advance();
        rd = '0;
        drain("reset_tail", 2);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        wr        = '0;
        rd        = '0;
        addr_bus  = '0;
        wdata_bus = '0;
        be_bus    = '0;
        ctl_rdata = '0;
        rst_n     = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        test_reset();
        test_rr_writes();
        test_fixed_priority();
        test_read_latency();
        test_wr_rd_same();
        test_random();
        test_withhold();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
